arc4_ctrl: RTL and testbench
============================

# arc4_ctrl

Top-level sequencer for the ARC4 decryption datapath. It runs the three sub-blocks in order: S-table init (S[i]=i), key scheduling (ksa), then keystream/decrypt (prga). It talks to each sub-block over the en/rdy handshake and owns the single S-memory port, multiplexing it to whichever sub-block is active. The ct and pt memories are wired directly to prga and do not pass through this block.

## Interface
- `WDOG_CYCLES`, default 4096: per-phase cycle limit. Used only when ARC4_WATCHDOG_EN is defined.
- `clk` in 1: clock. Every flop is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: start request. Accepted only while `rdy`=1.
- `rdy` out 1: 1 = idle and able to accept `en`.
- `key` in 24: key. Captured when `en` is accepted.
- `err` out 1: sticky watchdog-abort flag.
- `key_q` out 24: latched key, driven to ksa and prga.
- `init_en`, `ksa_en`, `prga_en` out 1 each: start pulses to the sub-blocks.
- `init_rdy`, `ksa_rdy`, `prga_rdy` in 1 each: ready signals from the sub-blocks.
- `init_addr`/`init_wrdata`/`init_wren`: inputs, widths 8/8/1. Init's S-memory request.
- `ksa_addr`/`ksa_wrdata`/`ksa_wren`: inputs, widths 8/8/1. KSA's S-memory request.
- `prga_addr`/`prga_wrdata`/`prga_wren`: inputs, widths 8/8/1. PRGA's S-memory request.
- `s_addr`/`s_wrdata`/`s_wren`: outputs, widths 8/8/1. To the S memory. `s_rddata` is wired to all three sub-blocks outside this block.

## Operation
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT.
- IDLE:
  - `rdy`=1.
  - If `en`=1: latch `key` into `key_q`, clear `err`, go to INIT_GO. `rdy`=0 from the next cycle.
- X_GO (X = init, ksa, prga):
  - `X_en` = `X_rdy`, combinational, so it is high only in this state.
  - If `X_rdy`=1, go to X_WAIT. Otherwise stay in X_GO; the stall is unbounded.
- X_WAIT:
  - `X_en`=0.
  - Sub-blocks drop rdy the cycle after they sample en, so WAIT exits only on `X_rdy`=1.
  - Transitions: INIT_WAIT→KSA_GO, KSA_WAIT→PRGA_GO, PRGA_WAIT→IDLE.
- S-memory mux, selected from the state:
  - INIT_* → init inputs.
  - KSA_* → ksa inputs.
  - PRGA_* → prga inputs.
  - IDLE → `s_addr`=0, `s_wrdata`=0, `s_wren`=0.
  - A wren from a non-owning sub-block never reaches `s_wren`.
- `en` while `rdy`=0 is ignored; `key_q` does not change.
- `key_q` is held stable from acceptance until the next accepted `en`.
- Exactly one `*_en` may be high in any cycle. The bench checks this as an assertion.
- Reset values: state IDLE, `rdy`=1, `err`=0, `key_q`=0, all `*_en`=0, S outputs 0.
- Reset mid-run: return to IDLE immediately. Sub-blocks share the reset and also return to idle; S contents are undefined afterwards.

## Timing
- Accept: `en` sampled at edge t → INIT_GO during cycle t+1; `init_en` is high in t+1 if `init_rdy`=1.
- Phase handoff: WAIT sees `X_rdy`=1 at edge u → next GO state during u+1, so there is one bubble cycle between phases.
- Completion: `prga_rdy` sampled 1 in PRGA_WAIT at edge v → `rdy`=1 during cycle v+1.
- Controller overhead: 4 cycles plus the sub-block latencies.
- Mux is purely combinational from state, so it adds no latency on the S path.

## Configuration
- `ARC4_WATCHDOG_EN` defined:
  - A 16-bit counter clears in every GO state and increments each WAIT cycle.
  - If it reaches `WDOG_CYCLES`-1 while `X_rdy`=0: go to IDLE, set `err`=1.
  - `err` holds until the next accepted `en`.
  - The aborted sub-block is not reset; its next GO stalls until its rdy returns.
- `ARC4_WATCHDOG_EN` undefined: no counter, `err` tied 0, WAIT states have no limit.

## Structure
- `arc4_pkg` holds:
  - the state enum `arc4_state_e`;
  - the owner enum `s_owner_e` (NONE/INIT/KSA/PRGA);
  - the default `WDOG_CYCLES` constant.
- Sub-module `arc4_smux`: a 3:1 S-port mux driven by `s_owner_e`, holding only combinational logic.
- FSM, key latch and watchdog stay in `arc4_ctrl`.

## Test plan
- Normal run: stubs with rdy-low durations 256/768/40 cycles, key=24'h1E4600 → `init_en`, `ksa_en`, `prga_en` each pulse exactly once, in order. `rdy` returns 1 exactly 4+256+768+40 cycles after `en`.
- Busy `en`: pulse `en` with key=24'hFFFFFF during KSA → `key_q` stays 24'h1E4600 and there is no extra `init_en`.
- GO stall: hold `ksa_rdy`=0 for 10 cycles on entering KSA_GO → `ksa_en` is first high on the cycle `ksa_rdy` rises, and the state stays KSA_GO until then.
- Mux isolation: ksa stub drives wren=1, addr=8'h55 during the INIT phase → `s_wren` follows init only. In IDLE, `s_wren`=0.
- Reset mid-PRGA: assert `rst` → `rdy`=1, all en=0, `s_wren`=0 without waiting for a clock edge. A fresh `en` completes normally.
- Watchdog (macro on, `WDOG_CYCLES`=64): prga stub never raises rdy → IDLE with `err`=1 after 64 WAIT cycles. The next `en` clears `err`.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 controller: FSM states, S-port owner codes and
// the default watchdog limit.
package arc4_pkg;

   localparam int unsigned WDOG_CYCLES_DEFAULT = 4096;

   typedef enum logic [2:0] {
      IDLE,
      INIT_GO,
      INIT_WAIT,
      KSA_GO,
      KSA_WAIT,
      PRGA_GO,
      PRGA_WAIT
   } arc4_state_e;

   typedef enum logic [1:0] {
      NONE,
      INIT,
      KSA,
      PRGA
   } s_owner_e;

   // The owning sub-block follows directly from the phase the FSM is in.
   function automatic s_owner_e owner_of(input arc4_state_e st);
      s_owner_e own;
      own = NONE;
      case (st)
         INIT_GO, INIT_WAIT: own = INIT;
         KSA_GO, KSA_WAIT:   own = KSA;
         PRGA_GO, PRGA_WAIT: own = PRGA;
         default:            own = NONE;
      endcase
      return own;
   endfunction

   function automatic logic is_wait(input arc4_state_e st);
      return (st == INIT_WAIT) || (st == KSA_WAIT) || (st == PRGA_WAIT);
   endfunction

endpackage

// File: rtl/arc4_ctrl_if.sv
// Host handshake, sub-block handshakes and S-memory port of arc4_ctrl.
// slave = controller side, master = surrounding datapath / environment.
interface arc4_ctrl_if;

   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic        err;
   logic [23:0] key_q;

   logic        init_en;
   logic        ksa_en;
   logic        prga_en;
   logic        init_rdy;
   logic        ksa_rdy;
   logic        prga_rdy;

   logic [7:0]  init_addr;
   logic [7:0]  init_wrdata;
   logic        init_wren;
   logic [7:0]  ksa_addr;
   logic [7:0]  ksa_wrdata;
   logic        ksa_wren;
   logic [7:0]  prga_addr;
   logic [7:0]  prga_wrdata;
   logic        prga_wren;

   logic [7:0]  s_addr;
   logic [7:0]  s_wrdata;
   logic        s_wren;

   modport slave (
      input  en, key,
      input  init_rdy, ksa_rdy, prga_rdy,
      input  init_addr, init_wrdata, init_wren,
      input  ksa_addr, ksa_wrdata, ksa_wren,
      input  prga_addr, prga_wrdata, prga_wren,
      output rdy, err, key_q,
      output init_en, ksa_en, prga_en,
      output s_addr, s_wrdata, s_wren
   );

   modport master (
      output en, key,
      output init_rdy, ksa_rdy, prga_rdy,
      output init_addr, init_wrdata, init_wren,
      output ksa_addr, ksa_wrdata, ksa_wren,
      output prga_addr, prga_wrdata, prga_wren,
      input  rdy, err, key_q,
      input  init_en, ksa_en, prga_en,
      input  s_addr, s_wrdata, s_wren
   );

endinterface

// File: rtl/arc4_smux.sv
// 3:1 S-memory port mux; purely combinational, selected by the current owner.
module arc4_smux
   import arc4_pkg::*;
(
   input  s_owner_e   owner,
   input  logic [7:0] init_addr,
   input  logic [7:0] init_wrdata,
   input  logic       init_wren,
   input  logic [7:0] ksa_addr,
   input  logic [7:0] ksa_wrdata,
   input  logic       ksa_wren,
   input  logic [7:0] prga_addr,
   input  logic [7:0] prga_wrdata,
   input  logic       prga_wren,
   output logic [7:0] s_addr,
   output logic [7:0] s_wrdata,
   output logic       s_wren
);

   always_comb begin
      s_addr   = '0;
      s_wrdata = '0;
      s_wren   = 1'b0;
      case (owner)
         INIT: begin
            s_addr   = init_addr;
            s_wrdata = init_wrdata;
            s_wren   = init_wren;
         end
         KSA: begin
            s_addr   = ksa_addr;
            s_wrdata = ksa_wrdata;
            s_wren   = ksa_wren;
         end
         PRGA: begin
            s_addr   = prga_addr;
            s_wrdata = prga_wrdata;
            s_wren   = prga_wren;
         end
         default: begin
            s_addr   = '0;
            s_wrdata = '0;
            s_wren   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/arc4_ctrl.sv
// ARC4 top sequencer: runs init -> ksa -> prga over en/rdy and owns the S port.
// Define ARC4_WATCHDOG_EN to enable the per-phase WDOG_CYCLES abort and err flag.
module arc4_ctrl
   import arc4_pkg::*;
#(
   parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
   input logic        clk,
   input logic        rst,
   arc4_ctrl_if.slave bus
);

   if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65536) begin : g_wdog_range
      $error("arc4_ctrl: WDOG_CYCLES must be in 2..65536");
   end

   arc4_state_e state;
   arc4_state_e state_nxt;
   s_owner_e    owner;
   logic        accept;
   logic        phase_rdy;
   logic        wdog_expired;
   logic        init_en;
   logic        ksa_en;
   logic        prga_en;
   logic        err;
   logic [23:0] key_q;

   assign accept = (state == IDLE) && bus.en;
   assign owner  = owner_of(state);

   always_comb begin
      phase_rdy = 1'b0;
      case (owner)
         INIT:    phase_rdy = bus.init_rdy;
         KSA:     phase_rdy = bus.ksa_rdy;
         PRGA:    phase_rdy = bus.prga_rdy;
         default: phase_rdy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // GO states forward the sub-block's rdy as its en, so a busy sub-block
   // simply stalls the FSM in GO without ever seeing a start pulse.
   always_comb begin
      state_nxt = state;
      init_en   = 1'b0;
      ksa_en    = 1'b0;
      prga_en   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.en) state_nxt = INIT_GO;
         end
         INIT_GO: begin
            init_en = bus.init_rdy;
            if (bus.init_rdy) state_nxt = INIT_WAIT;
         end
         INIT_WAIT: begin
            if (phase_rdy)         state_nxt = KSA_GO;
            else if (wdog_expired) state_nxt = IDLE;
         end
         KSA_GO: begin
            ksa_en = bus.ksa_rdy;
            if (bus.ksa_rdy) state_nxt = KSA_WAIT;
         end
         KSA_WAIT: begin
            if (phase_rdy)         state_nxt = PRGA_GO;
            else if (wdog_expired) state_nxt = IDLE;
         end
         PRGA_GO: begin
            prga_en = bus.prga_rdy;
            if (bus.prga_rdy) state_nxt = PRGA_WAIT;
         end
         PRGA_WAIT: begin
            if (phase_rdy || wdog_expired) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q <= '0;
      end else if (accept) begin
         key_q <= bus.key;
      end
   end

`ifdef ARC4_WATCHDOG_EN
   localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);

   logic [15:0] wdog_cnt;
   logic        in_wait;

   assign in_wait      = is_wait(state);
   assign wdog_expired = in_wait && (wdog_cnt == WDOG_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_cnt <= '0;
      end else if (in_wait) begin
         wdog_cnt <= wdog_cnt + 16'd1;
      end else begin
         wdog_cnt <= '0;
      end
   end

   // A sub-block finishing on the limit cycle wins over the abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (accept) begin
         err <= 1'b0;
      end else if (wdog_expired && !phase_rdy) begin
         err <= 1'b1;
      end
   end
`else
   assign wdog_expired = 1'b0;
   assign err          = 1'b0;
`endif

   assign bus.rdy     = (state == IDLE);
   assign bus.err     = err;
   assign bus.key_q   = key_q;
   assign bus.init_en = init_en;
   assign bus.ksa_en  = ksa_en;
   assign bus.prga_en = prga_en;

   arc4_smux u_smux (
      .owner       (owner),
      .init_addr   (bus.init_addr),
      .init_wrdata (bus.init_wrdata),
      .init_wren   (bus.init_wren),
      .ksa_addr    (bus.ksa_addr),
      .ksa_wrdata  (bus.ksa_wrdata),
      .ksa_wren    (bus.ksa_wren),
      .prga_addr   (bus.prga_addr),
      .prga_wrdata (bus.prga_wrdata),
      .prga_wren   (bus.prga_wren),
      .s_addr      (bus.s_addr),
      .s_wrdata    (bus.s_wrdata),
      .s_wren      (bus.s_wren)
   );

endmodule

// File: tb/tb_arc4_ctrl.sv
// Directed self-checking bench for arc4_ctrl with latency-programmable sub-block stubs.
// A stub with latency L returns rdy L cycles after the cycle its en is high.
module tb_arc4_ctrl;
   import arc4_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arc4_ctrl_if bus ();

`ifdef ARC4_WATCHDOG_EN
   arc4_ctrl #(.WDOG_CYCLES(64)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
   arc4_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   int unsigned checks   = 0;
   int unsigned failures = 0;

   int unsigned init_lat = 3;
   int unsigned ksa_lat  = 3;
   int unsigned prga_lat = 3;
   logic        ksa_hold = 1'b0;
   logic [15:0] init_cnt, ksa_cnt, prga_cnt;

   int unsigned cyc = 0;
   int unsigned init_pulses = 0, ksa_pulses = 0, prga_pulses = 0;
   int unsigned init_at = 0, ksa_at = 0, prga_at = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.init_en) begin init_pulses <= init_pulses + 1; init_at <= cyc; end
      if (bus.ksa_en)  begin ksa_pulses  <= ksa_pulses + 1;  ksa_at  <= cyc; end
      if (bus.prga_en) begin prga_pulses <= prga_pulses + 1; prga_at <= cyc; end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         init_cnt <= '0;
         ksa_cnt  <= '0;
         prga_cnt <= '0;
      end else begin
         if (bus.init_en)        init_cnt <= 16'(init_lat - 1);
         else if (init_cnt != 0) init_cnt <= init_cnt - 16'd1;
         if (bus.ksa_en)         ksa_cnt  <= 16'(ksa_lat - 1);
         else if (ksa_cnt != 0)  ksa_cnt  <= ksa_cnt - 16'd1;
         if (bus.prga_en)        prga_cnt <= 16'(prga_lat - 1);
         else if (prga_cnt != 0) prga_cnt <= prga_cnt - 16'd1;
      end
   end

   assign bus.init_rdy = (init_cnt == 16'd0);
   assign bus.ksa_rdy  = (ksa_cnt == 16'd0) && !ksa_hold;
   assign bus.prga_rdy = (prga_cnt == 16'd0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("en_onehot", 32'($onehot0({bus.init_en, bus.ksa_en, bus.prga_en})), 32'd1);
   endtask

   task automatic start(input logic [23:0] k);
      bus.key = k;
      bus.en  = 1'b1;
      tick();
      bus.en  = 1'b0;
      bus.key = 24'h000000;
   endtask

   task automatic wait_idle(input string tag, input int unsigned bound, output int unsigned n);
      n = 1;
      while (!bus.rdy && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.rdy), 32'd1);
   endtask

   task automatic wait_state(input string tag, input arc4_state_e st);
      int unsigned n;
      n = 0;
      while (dut.state != st && n < 3000) begin
         tick();
         n++;
      end
      chk(tag, 32'(dut.state), 32'(st));
   endtask

   initial begin
      int unsigned n;
      int unsigned b_init, b_ksa, b_prga;

      bus.en = 1'b0; bus.key = '0;
      bus.init_addr = 8'h12; bus.init_wrdata = 8'h34; bus.init_wren = 1'b0;
      bus.ksa_addr  = 8'h55; bus.ksa_wrdata  = 8'hAA; bus.ksa_wren  = 1'b1;
      bus.prga_addr = 8'h77; bus.prga_wrdata = 8'h88; bus.prga_wren = 1'b1;

      // Reset state
      #2;
      chk("rst_rdy", 32'(bus.rdy), 32'd1);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_key_q", 32'(bus.key_q), 32'd0);
      chk("rst_ens", 32'({bus.init_en, bus.ksa_en, bus.prga_en}), 32'd0);
      chk("rst_s_wren", 32'(bus.s_wren), 32'd0);
      chk("rst_s_addr", 32'(bus.s_addr), 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Normal run 256/768/40, with mux isolation and a busy en in KSA
      init_lat = 256; ksa_lat = 768; prga_lat = 40;
      b_init = init_pulses; b_ksa = ksa_pulses; b_prga = prga_pulses;
      start(24'h1E4600);
      chk("accept_key_q", 32'(bus.key_q), 32'h1E4600);
      chk("accept_rdy", 32'(bus.rdy), 32'd0);
      chk("accept_init_en", 32'(bus.init_en), 32'd1);
      bus.init_wren = 1'b1;
      #1;
      chk("mux_init_addr", 32'(bus.s_addr), 32'h12);
      chk("mux_init_wrdata", 32'(bus.s_wrdata), 32'h34);
      chk("mux_init_wren", 32'(bus.s_wren), 32'd1);
      bus.init_wren = 1'b0;
      #1;
      chk("mux_init_isolate", 32'(bus.s_wren), 32'd0);
      n = 1;
      while (!bus.rdy && n < 5000) begin
         tick();
         n++;
         if (n == 600) begin
            chk("mux_ksa_addr", 32'(bus.s_addr), 32'h55);
            chk("mux_ksa_wren", 32'(bus.s_wren), 32'd1);
            bus.key = 24'hFFFFFF;
            bus.en  = 1'b1;
         end
         if (n == 601) begin
            bus.en  = 1'b0;
            bus.key = 24'h000000;
         end
         if (n == 700) chk("busy_key_q", 32'(bus.key_q), 32'h1E4600);
         if (n == 1050) chk("mux_prga_addr", 32'(bus.s_addr), 32'h77);
      end
      chk("run_latency", n, 32'd1068);
      chk("run_rdy", 32'(bus.rdy), 32'd1);
      chk("run_key_q", 32'(bus.key_q), 32'h1E4600);
      chk("init_pulses", init_pulses - b_init, 32'd1);
      chk("ksa_pulses", ksa_pulses - b_ksa, 32'd1);
      chk("prga_pulses", prga_pulses - b_prga, 32'd1);
      chk("pulse_order", 32'((init_at < ksa_at) && (ksa_at < prga_at)), 32'd1);
      chk("idle_s_wren", 32'(bus.s_wren), 32'd0);
      chk("idle_s_addr", 32'(bus.s_addr), 32'd0);
      chk("run_err", 32'(bus.err), 32'd0);
      tick();

      // GO stall: ksa_rdy held low for 10 cycles after entering KSA_GO
      init_lat = 3; ksa_lat = 3; prga_lat = 3;
      ksa_hold = 1'b1;
      start(24'h0A0B0C);
      wait_state("reach_ksa_go", KSA_GO);
      for (int i = 0; i < 10; i++) begin
         chk("stall_ksa_en", 32'(bus.ksa_en), 32'd0);
         chk("stall_state", 32'(dut.state), 32'(KSA_GO));
         tick();
      end
      ksa_hold = 1'b0;
      #1;
      chk("stall_release_en", 32'(bus.ksa_en), 32'd1);
      tick();
      chk("stall_to_wait", 32'(dut.state), 32'(KSA_WAIT));
      wait_idle("stall_done", 200, n);
      tick();

      // Reset mid-PRGA, then a fresh run 3/4/5
      prga_lat = 50;
      start(24'h123456);
      wait_state("reach_prga_wait", PRGA_WAIT);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_rdy", 32'(bus.rdy), 32'd1);
      chk("midrst_ens", 32'({bus.init_en, bus.ksa_en, bus.prga_en}), 32'd0);
      chk("midrst_s_wren", 32'(bus.s_wren), 32'd0);
      chk("midrst_key_q", 32'(bus.key_q), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      init_lat = 3; ksa_lat = 4; prga_lat = 5;
      start(24'hC0FFEE);
      wait_idle("fresh_done", 200, n);
      chk("fresh_latency", n, 32'd16);
      chk("fresh_key_q", 32'(bus.key_q), 32'hC0FFEE);

`ifdef ARC4_WATCHDOG_EN
      // Watchdog: prga far slower than the 64-cycle limit
      tick();
      init_lat = 3; ksa_lat = 3; prga_lat = 1000;
      start(24'h00BEEF);
      wait_state("wd_reach_prga_wait", PRGA_WAIT);
      n = 1;
      while (dut.state == PRGA_WAIT && n < 500) begin
         tick();
         if (dut.state == PRGA_WAIT) n++;
      end
      chk("wd_wait_cycles", n, 32'd64);
      chk("wd_rdy", 32'(bus.rdy), 32'd1);
      chk("wd_err", 32'(bus.err), 32'd1);
      tick();
      chk("wd_err_sticky", 32'(bus.err), 32'd1);
      prga_lat = 3;
      start(24'h00CAFE);
      chk("wd_err_cleared", 32'(bus.err), 32'd0);
      wait_idle("wd_rerun_done", 2000, n);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
